alu_flag_unit: RTL
==================

// Module: alu_flag_unit
// PURPOSE
//  Two-stage valid/ready pipeline directly downstream of the 64-bit ALU datapath.
//  Stage A registers the ALU result together with its carry and overflow bits.
//  Stage B updates the architectural NZCV flag register and presents the result.
//  Z comes from a zero_checker instance driven by stage A's registered result.
//  Also evaluates ARM condition codes against committed NZCV for B.cond/CSEL.
// PARAMETERS
//  DATA_W    64       datapath width; fixed at 64 (zero_checker is 64-bit only)
//  FLAG_RST  4'b0000  reset value of NZCV register, bit order {N,Z,C,V}
// PORTS
//  clk           in   1   single clock, all state on posedge
//  reset_n       in   1   synchronous reset, active-low
//  in_valid      in   1   ALU result present on in_* this cycle
//  in_ready      out  1   stage A can accept (transfer = in_valid & in_ready)
//  in_result     in   64  ALU result
//  in_carry      in   1   ALU carry-out
//  in_overflow   in   1   ALU signed overflow
//  in_set_flags  in   1   instruction writes NZCV (ADDS/SUBS/ANDS)
//  flush         in   1   kill all in-flight entries (branch mispredict)
//  out_valid     out  1   stage B holds a completed entry
//  out_ready     in   1   consumer accepts (retire = out_valid & out_ready)
//  out_result    out  64  stage B result
//  out_is_zero   out  1   result==0 for this entry, independent of set_flags (CBZ)
//  nzcv          out  4   committed flags {N,Z,C,V}
//  flags_pending out  1   a set_flags entry sits in stage A; nzcv is stale
//  cond_code     in   4   ARM condition field
//  cond_true     out  1   cond_code evaluated on committed nzcv (combinational)
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge):
//    a_valid=0, out_valid=0, nzcv=FLAG_RST, out_result=0, out_is_zero=0.
//    Overrides flush and any handshake; an entry in flight is dropped.
//  - in_ready = !a_valid | a_adv, where a_adv = a_valid & (!out_valid | out_ready).
//    Full throughput: 1 entry/cycle with no bubbles.
//  - Latency: accepted at edge k, out_valid at edge k+1, nzcv updated at edge k+1.
//  - Stage A on transfer: latch result, carry, overflow, set_flags.
//    a_valid stays set until a_adv; if not accepting, hold all stage A contents.
//  - Z = zero_checker(a_result).is_zero (~35 time units of gate delay).
//    Clock period must exceed this. No combinational path from in_result to Z.
//  - On a_adv:
//    out_result <= a_result; out_is_zero <= Z; out_valid <= 1.
//    If a_set_flags: nzcv <= {a_result[63], Z, a_carry, a_overflow}.
//    If !a_set_flags: nzcv holds.
//  - Retire without a_adv: out_valid <= 0. Stall (out_valid & !out_ready): stage B holds.
//  - flags_pending = a_valid & a_set_flags. The consumer stalls cond users while set.
//    No bypass path.
//  - flush=1 at posedge: a_valid <= 0, out_valid <= 0, no nzcv update that edge.
//    in_ready is forced to 0 during flush, so nothing is accepted that cycle.
//  - cond_true, with cond_code[3:1] selecting the base test and cond_code[0] inverting it:
//    000 Z; 001 C; 010 N; 011 V; 100 C&!Z; 101 N==V; 110 !Z&(N==V); 111 1.
//    Both 1110 and 1111 are always true (AArch64 NV = AL).
//  - Arithmetic: pure pass-through. N is taken from a_result[63]; nothing is recomputed.
// TESTING
//  1. Reset mid-stream: 3 back-to-back set_flags entries, reset_n=0 on cycle 2.
//     -> out_valid=0, nzcv=0000, in_ready=1 next cycle, no stale retire.
//  2. in_result=0, carry=1, set_flags=1.
//     -> next cycle nzcv=0110, out_is_zero=1; cond EQ/HS true, NE false.
//  3. in_result=64'h8000_0000_0000_0000, ovf=1, set_flags=1, then in_result=0 with set_flags=0.
//     -> nzcv=1001 and stays 1001; second entry out_is_zero=1.
//     -> LT false, GE true, MI true.
//  4. Backpressure: out_ready=0 for 3 cycles while 2 entries are sent.
//     -> in_ready drops after the 2nd; entries retire in order once out_ready=1.
//     -> nzcv reflects each entry exactly when it moves into stage B.
//  5. flush with set_flags entries in both stages.
//     -> both valids clear, nzcv unchanged from the pre-flush value, flags_pending=0.
//  6. Sweep all 16 cond_code values × 16 nzcv values against the reference table.
//     -> 256/256 match.

Source files
------------

// File: rtl/alu_flag_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// zero_checker
//   64-bit zero detector built as a two-level OR tree.
//   value   in  64  word under test
//   is_zero out 1   high when every bit of value is zero
// ---------------------------------------------------------------------------
module zero_checker (
  input  logic [63:0] value,
  output logic        is_zero
);

  logic [15:0] nibble_any;

  always_comb begin
    nibble_any = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      nibble_any[i] = |value[i*4 +: 4];
    end
    is_zero = ~|nibble_any;
  end

endmodule

// ---------------------------------------------------------------------------
// alu_flag_unit
//   Two-stage valid/ready pipeline behind the 64-bit ALU. Stage A registers
//   the ALU result with carry/overflow; stage B presents the result and
//   commits the NZCV flag register. Also evaluates ARM condition codes
//   against the committed flags.
//
//   clk           in   1   clock, all state on posedge
//   reset_n       in   1   synchronous active-low reset
//   in_valid      in   1   ALU result present
//   in_ready      out  1   stage A can accept
//   in_result     in   64  ALU result
//   in_carry      in   1   ALU carry-out
//   in_overflow   in   1   ALU signed overflow
//   in_set_flags  in   1   instruction writes NZCV
//   flush         in   1   kill all in-flight entries
//   out_valid     out  1   stage B holds a completed entry
//   out_ready     in   1   consumer accepts
//   out_result    out  64  stage B result
//   out_is_zero   out  1   result==0 for this entry (CBZ)
//   nzcv          out  4   committed flags {N,Z,C,V}
//   flags_pending out  1   set_flags entry in stage A; nzcv is stale
//   cond_code     in   4   ARM condition field
//   cond_true     out  1   cond_code evaluated on committed nzcv
// ---------------------------------------------------------------------------
module alu_flag_unit #(
  parameter int unsigned DATA_W   = 64,
  parameter logic [3:0]  FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_overflow,
  input  logic              in_set_flags,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_is_zero,
  output logic [3:0]        nzcv,
  output logic              flags_pending,
  input  logic [3:0]        cond_code,
  output logic              cond_true
);

  logic              a_valid;
  logic [DATA_W-1:0] a_result;
  logic              a_carry;
  logic              a_overflow;
  logic              a_set_flags;
  logic              a_adv;
  logic              a_zero;
  logic              cond_base;

  // Z is derived only from the registered stage A result, never from in_result.
  zero_checker u_zero_checker (
    .value   (a_result),
    .is_zero (a_zero)
  );

  assign a_adv         = a_valid & (~out_valid | out_ready);
  assign in_ready      = ~flush & (~a_valid | a_adv);
  assign flags_pending = a_valid & a_set_flags;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid     <= 1'b0;
      a_result    <= '0;
      a_carry     <= 1'b0;
      a_overflow  <= 1'b0;
      a_set_flags <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_is_zero <= 1'b0;
      nzcv        <= FLAG_RST;
    end else if (flush) begin
      a_valid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (a_adv) begin
        out_result  <= a_result;
        out_is_zero <= a_zero;
        out_valid   <= 1'b1;
        if (a_set_flags) begin
          nzcv <= {a_result[DATA_W-1], a_zero, a_carry, a_overflow};
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_valid && in_ready) begin
        a_valid     <= 1'b1;
        a_result    <= in_result;
        a_carry     <= in_carry;
        a_overflow  <= in_overflow;
        a_set_flags <= in_set_flags;
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
    end
  end

  // cond_code[3:1] picks the base test, cond_code[0] inverts it, except the
  // 111x group which is always true (NV behaves as AL).
  always_comb begin
    cond_base = 1'b0;
    unique case (cond_code[3:1])
      3'b000: cond_base = nzcv[2];
      3'b001: cond_base = nzcv[1];
      3'b010: cond_base = nzcv[3];
      3'b011: cond_base = nzcv[0];
      3'b100: cond_base = nzcv[1] & ~nzcv[2];
      3'b101: cond_base = (nzcv[3] == nzcv[0]);
      3'b110: cond_base = ~nzcv[2] & (nzcv[3] == nzcv[0]);
      3'b111: cond_base = 1'b1;
      default: cond_base = 1'b0;
    endcase
    cond_true = (cond_code[3:1] == 3'b111) ? 1'b1 : (cond_base ^ cond_code[0]);
  end

endmodule
